// File: rtl/lin_pkg.sv
// rtl/lin_pkg.sv - shared types and constants for the linearizer table sequencer
package lin_pkg;

   // Table sequencer control states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PEND   = 2'd1,
      SWAP   = 2'd2,
      SETTLE = 2'd3
   } state_t;

   // Curve select field of the host address
   localparam logic [1:0] CURVE_G1 = 2'd0;
   localparam logic [1:0] CURVE_G2 = 2'd1;
   localparam logic [1:0] CURVE_O1 = 2'd2;
   localparam logic [1:0] CURVE_O2 = 2'd3;

   // Last phase of the four-way interleave; a frame ends on it
   localparam logic [1:0] QPHASE_LAST = 2'd3;

endpackage

// File: rtl/lin_qphase_gen.sv
// rtl/lin_qphase_gen.sv - enabled 2-bit interleave phase counter with frame boundary flag
module lin_qphase_gen
   import lin_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   output logic [1:0] qphase,
   output logic       boundary
);

   // Phase advances only while enabled and holds its value otherwise
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         qphase <= 2'd0;
      end else if (enable) begin
         qphase <= qphase + 2'd1;
      end
   end

   // A frame ends on the last phase of an enabled cycle
   assign boundary = enable && (qphase == QPHASE_LAST);

endmodule

// File: rtl/lin_table_sched.sv
// rtl/lin_table_sched.sv - curve table write path and frame-aligned bank swap sequencer
module lin_table_sched
   import lin_pkg::*;
#(
   parameter int aw     = 6,
   parameter int dw     = 16,
   parameter int settle = 12
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          enable,
   input  logic          host_we,
   input  logic [aw+1:0] host_addr,
   input  logic [dw-1:0] host_data,
   input  logic          host_commit,
   output logic          host_busy,
   output logic          host_done,
   output logic          host_err,
   output logic [1:0]    qphase,
   output logic          bank_sel,
   output logic          tbl_we,
   output logic [aw+2:0] tbl_waddr,
   output logic [dw-1:0] tbl_wdata,
   output logic [15:0]   swap_count
);

   localparam int cw = (settle > 1) ? $clog2(settle) : 1;

   state_t          state;
   logic [cw-1:0]   settle_cnt;
   logic            boundary;
   logic            wr_accept;

   lin_qphase_gen u_qphase (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable   (enable),
      .qphase   (qphase),
      .boundary (boundary)
   );

   // Host writes are only honoured while no swap is in flight
   assign wr_accept = host_we && (state == IDLE);

   // Register accepted writes toward the shadow bank, never the active one
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tbl_we    <= 1'b0;
         tbl_waddr <= '0;
         tbl_wdata <= '0;
      end else begin
         tbl_we <= wr_accept;
         if (wr_accept) begin
            tbl_waddr <= {~bank_sel, host_addr};
            tbl_wdata <= host_data;
         end
      end
   end

   // Commit sequencing: wait for frame end, flip banks, then let the pipeline drain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         settle_cnt <= '0;
         bank_sel   <= 1'b0;
         host_busy  <= 1'b0;
         host_done  <= 1'b0;
         host_err   <= 1'b0;
         swap_count <= 16'd0;
      end else begin
         host_done <= 1'b0;
         if ((state != IDLE) && (host_we || host_commit)) begin
            host_err <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (host_commit) begin
                  state     <= PEND;
                  host_busy <= 1'b1;
                  host_err  <= 1'b0;
               end
            end
            PEND: begin
               if (boundary) begin
                  state <= SWAP;
               end
            end
            SWAP: begin
               bank_sel   <= ~bank_sel;
               settle_cnt <= cw'(settle - 1);
               state      <= SETTLE;
            end
            SETTLE: begin
               if (settle_cnt == '0) begin
                  host_done  <= 1'b1;
                  host_busy  <= 1'b0;
                  swap_count <= swap_count + 16'd1;
                  state      <= IDLE;
               end else begin
                  settle_cnt <= settle_cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lin_table_sched.sv
// tb/tb_lin_table_sched.sv - scoreboard bench for lin_table_sched
module tb_lin_table_sched;

   localparam int AW     = 6;
   localparam int DW     = 16;
   localparam int SETTLE = 12;

   typedef struct packed {
      logic [1:0]  q;
      logic        bank;
      logic        busy;
      logic        done;
      logic        err;
      logic        we;
      logic [15:0] cnt;
   } st_t;

   typedef struct packed {
      logic [AW+2:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          enable = 1'b0;
   logic          host_we = 1'b0;
   logic [AW+1:0] host_addr = '0;
   logic [DW-1:0] host_data = '0;
   logic          host_commit = 1'b0;
   logic          host_busy, host_done, host_err, bank_sel, tbl_we;
   logic [1:0]    qphase;
   logic [AW+2:0] tbl_waddr;
   logic [DW-1:0] tbl_wdata;
   logic [15:0]   swap_count;

   always #5 clk = ~clk;

   lin_table_sched #(.aw(AW), .dw(DW), .settle(SETTLE)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .host_we     (host_we),
      .host_addr   (host_addr),
      .host_data   (host_data),
      .host_commit (host_commit),
      .host_busy   (host_busy),
      .host_done   (host_done),
      .host_err    (host_err),
      .qphase      (qphase),
      .bank_sel    (bank_sel),
      .tbl_we      (tbl_we),
      .tbl_waddr   (tbl_waddr),
      .tbl_wdata   (tbl_wdata),
      .swap_count  (swap_count)
   );

   int  checks = 0;
   int  failures = 0;
   int  cyc = 0;
   bit  mon_on = 1'b0;
   st_t sq[$];
   wr_t wq[$];
   st_t e;
   wr_t w;

   // Reference model: visible values of the current cycle plus a swap timeline
   int          mq;
   bit          mbank, mbusy, merr, waiting;
   logic [15:0] mcnt;
   int          swap_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h cycle=%0d", name, act, exp, cyc);
      end
   endtask

   // Monitor: compare each cycle's outputs and every presented table write
   always @(negedge clk) begin
      if (mon_on) begin
         if (sq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL status_queue actual=empty required=entry cycle=%0d", cyc);
         end else begin
            e = sq.pop_front();
            chk("qphase", {30'd0, qphase}, {30'd0, e.q});
            chk("bank_sel", {31'd0, bank_sel}, {31'd0, e.bank});
            chk("host_busy", {31'd0, host_busy}, {31'd0, e.busy});
            chk("host_done", {31'd0, host_done}, {31'd0, e.done});
            chk("host_err", {31'd0, host_err}, {31'd0, e.err});
            chk("tbl_we", {31'd0, tbl_we}, {31'd0, e.we});
            chk("swap_count", {16'd0, swap_count}, {16'd0, e.cnt});
         end
         if (tbl_we === 1'b1) begin
            if (wq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL write_queue actual=unexpected_write required=none cycle=%0d", cyc);
            end else begin
               w = wq.pop_front();
               chk("tbl_waddr", {23'd0, tbl_waddr}, {23'd0, w.addr});
               chk("tbl_wdata", {16'd0, tbl_wdata}, {16'd0, w.data});
            end
         end
      end
   end

   function automatic st_t reset_status();
      st_t s;
      s = '0;
      return s;
   endfunction

   // Hold reset for n cycles; everything in flight is discarded
   task automatic do_reset(input int n);
      rst_n = 1'b0;
      enable = 1'b0;
      host_we = 1'b0;
      host_commit = 1'b0;
      sq.delete();
      wq.delete();
      mq = 0; mbank = 0; mbusy = 0; merr = 0; waiting = 0; mcnt = 16'd0; swap_t = -1;
      sq.push_back(reset_status());
      mon_on = 1'b1;
      repeat (n) begin
         @(posedge clk); #1; cyc++;
         sq.push_back(reset_status());
      end
      rst_n = 1'b1;
   endtask

   // Apply one cycle of inputs and predict the outputs visible next cycle
   task automatic step(input bit en, input bit we, input logic [AW+1:0] addr,
                       input logic [DW-1:0] data, input bit commit);
      st_t n;
      enable = en; host_we = we; host_addr = addr; host_data = data; host_commit = commit;
      n.q    = en ? 2'((mq + 1) % 4) : 2'(mq);
      n.bank = mbank;
      n.busy = mbusy;
      n.done = 1'b0;
      n.err  = merr;
      n.we   = 1'b0;
      n.cnt  = mcnt;
      if (we && !mbusy) begin
         wq.push_back({~mbank, addr, data});
         n.we = 1'b1;
      end
      if ((we || commit) && mbusy) n.err = 1'b1;
      if (commit && !mbusy) begin
         n.busy = 1'b1;
         n.err = 1'b0;
         waiting = 1;
      end else if (waiting && en && mq == 3) begin
         waiting = 0;
         swap_t = cyc + 1;
      end
      if (swap_t == cyc) n.bank = ~mbank;
      if (swap_t >= 0 && cyc == swap_t + SETTLE) begin
         n.done = 1'b1;
         n.busy = 1'b0;
         n.cnt = mcnt + 16'd1;
         swap_t = -1;
      end
      sq.push_back(n);
      mq = int'(n.q); mbank = n.bank; mbusy = n.busy; merr = n.err; mcnt = n.cnt;
      @(posedge clk); #1; cyc++;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1, 0, '0, '0, 0);
   endtask

   task automatic wait_not_busy(input int budget);
      int k = 0;
      while (mbusy && k < budget) begin
         step(1, 0, '0, '0, 0);
         k++;
      end
      if (mbusy) begin
         checks++;
         failures++;
         $display("FAIL idle_timeout actual=busy required=idle cycle=%0d", cyc);
      end
   endtask

   task automatic wait_qphase(input int ph);
      int k = 0;
      while (mq != ph && k < 8) begin
         step(1, 0, '0, '0, 0);
         k++;
      end
   endtask

   bit saved_bank;

   initial begin
      @(posedge clk); #1;
      do_reset(2);
      chk("reset_busy", {31'd0, host_busy}, 32'd0);
      chk("reset_bank", {31'd0, bank_sel}, 32'd0);

      // Free-running phase sequence, then the reference write into bank 1
      idle(6);
      step(1, 1, 8'h45, 16'h1234, 0);
      step(1, 0, '0, '0, 0);
      idle(2);

      // Reset in the middle of the settle window loses the swap
      step(1, 0, '0, '0, 1);
      begin
         int k = 0;
         while (!(swap_t >= 0 && cyc > swap_t + 3) && k < 20) begin
            step(1, 0, '0, '0, 0);
            k++;
         end
      end
      do_reset(2);
      idle(20);
      chk("count_after_settle_reset", {16'd0, swap_count}, 32'd0);
      chk("bank_after_settle_reset", {31'd0, bank_sel}, 32'd0);

      // Commit on qphase 1 and let the swap complete
      wait_qphase(1);
      step(1, 0, '0, '0, 1);
      chk("busy_after_commit", {31'd0, host_busy}, 32'd1);
      wait_not_busy(40);
      chk("count_first_swap", {16'd0, swap_count}, 32'd1);
      chk("bank_first_swap", {31'd0, bank_sel}, 32'd1);

      // Write during PEND is rejected and flagged; next commit clears the flag
      step(1, 0, '0, '0, 1);
      step(1, 1, {2'd2, 6'h3f}, 16'hbeef, 0);
      chk("err_after_pend_write", {31'd0, host_err}, 32'd1);
      wait_not_busy(40);
      step(1, 0, '0, '0, 1);
      chk("err_cleared_by_commit", {31'd0, host_err}, 32'd0);
      wait_not_busy(40);

      // Enable low during PEND freezes phase and defers the swap
      step(1, 0, '0, '0, 1);
      saved_bank = bank_sel;
      repeat (20) step(0, 0, '0, '0, 0);
      chk("bank_frozen", {31'd0, bank_sel}, {31'd0, saved_bank});
      wait_not_busy(40);

      // Randomized traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 499) == 0) begin
            do_reset($urandom_range(1, 3));
         end else begin
            step($urandom_range(0, 9) < 8, $urandom_range(0, 4) == 0,
                 AW'($urandom) | ((AW+2)'($urandom_range(0, 3)) << AW),
                 DW'($urandom), $urandom_range(0, 29) == 0);
         end
      end
      idle(4);
      chk("write_queue_drained", wq.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
